// File: rtl/bp_control_unit_if.sv
// ============================================================================
// Module      : bp_control_unit_if
// Description : Instruction-memory, data-memory, register-file and ALU control
//               bus between bp_control_unit and its datapath.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bp_control_unit_if;
  logic [7:0]  pc_addr;
  logic [15:0] i_data;
  logic        rf_rp_zero;
  logic [7:0]  d_addr;
  logic        d_rd;
  logic        d_wr;
  logic [1:0]  rf_s;
  logic [7:0]  rf_w_data;
  logic [3:0]  rf_w_addr;
  logic [3:0]  rf_rp_addr;
  logic [3:0]  rf_rq_addr;
  logic        rf_w_wr;
  logic        rf_rp_rd;
  logic        rf_rq_rd;
  logic [1:0]  alu_s;
  logic [3:0]  state_o;

  modport master (
    output pc_addr, d_addr, d_rd, d_wr, rf_s, rf_w_data, rf_w_addr,
           rf_rp_addr, rf_rq_addr, rf_w_wr, rf_rp_rd, rf_rq_rd, alu_s, state_o,
    input  i_data, rf_rp_zero
  );

  modport slave (
    input  pc_addr, d_addr, d_rd, d_wr, rf_s, rf_w_data, rf_w_addr,
           rf_rp_addr, rf_rq_addr, rf_w_wr, rf_rp_rd, rf_rq_rd, alu_s, state_o,
    output i_data, rf_rp_zero
  );
endinterface

`default_nettype wire

// File: rtl/bp_control_unit.sv
// ============================================================================
// Module      : bp_control_unit
// Description : Multi-cycle control unit: fetch/decode/execute FSM driving the
//               memories, register file and ALU of a small 8-bit processor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bp_control_unit #(
  parameter logic [7:0] PC_RESET = 8'h00
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  bp_control_unit_if.master bus
);

  typedef enum logic [3:0] {
    ST_INIT     = 4'd0,
    ST_FETCH    = 4'd1,
    ST_DECODE   = 4'd2,
    ST_LOAD     = 4'd3,
    ST_STORE    = 4'd4,
    ST_ADD      = 4'd5,
    ST_LDC      = 4'd6,
    ST_SUB      = 4'd7,
    ST_JMPZ     = 4'd8,
    ST_JMPZ_JMP = 4'd9
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [7:0]  r_pc;
  logic [15:0] r_ir;

  logic [3:0]  w_op;
  logic [3:0]  w_ra;
  logic [3:0]  w_rb;
  logic [3:0]  w_rc;
  logic [7:0]  w_k;

  assign w_op = r_ir[15:12];
  assign w_ra = r_ir[11:8];
  assign w_rb = r_ir[7:4];
  assign w_rc = r_ir[3:0];
  assign w_k  = r_ir[7:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_INIT;
      r_pc    <= PC_RESET;
      r_ir    <= 16'h0000;
    end else begin
      r_state <= w_next_state;
      if (r_state == ST_FETCH) begin
        r_ir <= bus.i_data;
        r_pc <= r_pc + 8'd1;
      end else if (r_state == ST_JMPZ_JMP) begin
        // PC already points past the jump, so the offset is taken from PC-1
        r_pc <= r_pc + w_k - 8'd1;
      end
    end
  end

  always_comb begin
    w_next_state = ST_FETCH;
    case (r_state)
      ST_INIT:   w_next_state = ST_FETCH;
      ST_FETCH:  w_next_state = ST_DECODE;
      ST_DECODE: begin
        case (w_op)
          4'h0:    w_next_state = ST_LOAD;
          4'h1:    w_next_state = ST_STORE;
          4'h2:    w_next_state = ST_ADD;
          4'h3:    w_next_state = ST_LDC;
          4'h4:    w_next_state = ST_SUB;
          4'h5:    w_next_state = ST_JMPZ;
          default: w_next_state = ST_FETCH;
        endcase
      end
      ST_JMPZ:   w_next_state = bus.rf_rp_zero ? ST_JMPZ_JMP : ST_FETCH;
      default:   w_next_state = ST_FETCH;
    endcase
  end

  logic [7:0] w_d_addr;
  logic       w_d_rd;
  logic       w_d_wr;
  logic [1:0] w_rf_s;
  logic [7:0] w_rf_w_data;
  logic [3:0] w_rf_w_addr;
  logic [3:0] w_rf_rp_addr;
  logic [3:0] w_rf_rq_addr;
  logic       w_rf_w_wr;
  logic       w_rf_rp_rd;
  logic       w_rf_rq_rd;
  logic [1:0] w_alu_s;

  always_comb begin
    w_d_addr     = 8'h00;
    w_d_rd       = 1'b0;
    w_d_wr       = 1'b0;
    w_rf_s       = 2'b00;
    w_rf_w_data  = 8'h00;
    w_rf_w_addr  = 4'h0;
    w_rf_rp_addr = 4'h0;
    w_rf_rq_addr = 4'h0;
    w_rf_w_wr    = 1'b0;
    w_rf_rp_rd   = 1'b0;
    w_rf_rq_rd   = 1'b0;
    w_alu_s      = 2'b00;
    case (r_state)
      ST_LOAD: begin
        w_d_addr    = w_k;
        w_d_rd      = 1'b1;
        w_rf_s      = 2'b01;
        w_rf_w_addr = w_ra;
        w_rf_w_wr   = 1'b1;
      end
      ST_STORE: begin
        w_d_addr     = w_k;
        w_d_wr       = 1'b1;
        w_rf_rp_addr = w_ra;
        w_rf_rp_rd   = 1'b1;
      end
      ST_ADD, ST_SUB: begin
        w_rf_rp_addr = w_rb;
        w_rf_rq_addr = w_rc;
        w_rf_rp_rd   = 1'b1;
        w_rf_rq_rd   = 1'b1;
        w_alu_s      = (r_state == ST_SUB) ? 2'b10 : 2'b01;
        w_rf_s       = 2'b00;
        w_rf_w_addr  = w_ra;
        w_rf_w_wr    = 1'b1;
      end
      ST_LDC: begin
        w_rf_s      = 2'b10;
        w_rf_w_data = w_k;
        w_rf_w_addr = w_ra;
        w_rf_w_wr   = 1'b1;
      end
      ST_JMPZ: begin
        w_rf_rp_addr = w_ra;
        w_rf_rp_rd   = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.pc_addr    = r_pc;
  assign bus.state_o    = r_state;
  assign bus.d_addr     = w_d_addr;
  assign bus.d_rd       = w_d_rd;
  assign bus.d_wr       = w_d_wr;
  assign bus.rf_s       = w_rf_s;
  assign bus.rf_w_data  = w_rf_w_data;
  assign bus.rf_w_addr  = w_rf_w_addr;
  assign bus.rf_rp_addr = w_rf_rp_addr;
  assign bus.rf_rq_addr = w_rf_rq_addr;
  assign bus.rf_w_wr    = w_rf_w_wr;
  assign bus.rf_rp_rd   = w_rf_rp_rd;
  assign bus.rf_rq_rd   = w_rf_rq_rd;
  assign bus.alu_s      = w_alu_s;

endmodule

`default_nettype wire

// File: tb/tb_bp_control_unit.sv
// ============================================================================
// Module      : tb_bp_control_unit
// Description : Self-checking bench for bp_control_unit, instruction-level
//               reference model producing one expected output set per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bp_control_unit;

  localparam logic [7:0] c_pc_reset = 8'h00;

  typedef struct packed {
    logic [3:0] st;
    logic [7:0] pc;
    logic [7:0] d_addr;
    logic       d_rd;
    logic       d_wr;
    logic [1:0] rf_s;
    logic [7:0] w_data;
    logic [3:0] wa;
    logic [3:0] pa;
    logic [3:0] qa;
    logic       w_wr;
    logic       p_rd;
    logic       q_rd;
    logic [1:0] alu;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [15:0] imem [256];
  logic [7:0]  m_pc;
  exp_t        exp_q [$];
  int          n_checks;
  int          n_errors;

  bp_control_unit_if bus ();

  bp_control_unit #(.PC_RESET(c_pc_reset)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.i_data = imem[bus.pc_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t blank(input logic [3:0] st, input logic [7:0] pc);
    exp_t e;
    e    = '0;
    e.st = st;
    e.pc = pc;
    return e;
  endfunction

  // Execute-cycle outputs for opcodes 0..5, read straight off the instruction table
  function automatic exp_t exec(input logic [15:0] ir, input logic [7:0] pc);
    exp_t e;
    logic [3:0] op;
    op = ir[15:12];
    e  = blank(op + 4'd3, pc);
    case (op)
      4'h0: begin e.d_addr = ir[7:0]; e.d_rd = 1; e.rf_s = 2'b01; e.wa = ir[11:8]; e.w_wr = 1; end
      4'h1: begin e.d_addr = ir[7:0]; e.d_wr = 1; e.pa = ir[11:8]; e.p_rd = 1; end
      4'h2, 4'h4: begin
        e.pa = ir[7:4]; e.qa = ir[3:0]; e.p_rd = 1; e.q_rd = 1;
        e.alu = (op == 4'h2) ? 2'b01 : 2'b10;
        e.wa = ir[11:8]; e.w_wr = 1;
      end
      4'h3: begin e.rf_s = 2'b10; e.w_data = ir[7:0]; e.wa = ir[11:8]; e.w_wr = 1; end
      4'h5: begin e.pa = ir[11:8]; e.p_rd = 1; end
      default: ;
    endcase
    return e;
  endfunction

  task automatic tick(input exp_t e);
    @(posedge clk);
    #1;
    exp_q.push_back(e);
  endtask

  task automatic run_instr(input bit zero, input bit chk_pc, input logic [7:0] lit_pc);
    logic [15:0] ir;
    tick(blank(4'd1, m_pc));
    if (chk_pc) chk("fetch_pc_lit", {8'h00, bus.pc_addr}, {8'h00, lit_pc});
    bus.rf_rp_zero = zero;
    ir   = imem[m_pc];
    m_pc = m_pc + 8'd1;
    tick(blank(4'd2, m_pc));
    if (ir[15:12] <= 4'd5) tick(exec(ir, m_pc));
    if (ir[15:12] == 4'd5 && zero) begin
      tick(blank(4'd9, m_pc));
      m_pc = m_pc + ir[7:0] - 8'd1;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("state_o",    {12'h0, bus.state_o},    {12'h0, e.st});
      chk("pc_addr",    {8'h0,  bus.pc_addr},    {8'h0,  e.pc});
      chk("d_addr",     {8'h0,  bus.d_addr},     {8'h0,  e.d_addr});
      chk("d_rd",       {15'h0, bus.d_rd},       {15'h0, e.d_rd});
      chk("d_wr",       {15'h0, bus.d_wr},       {15'h0, e.d_wr});
      chk("rf_s",       {14'h0, bus.rf_s},       {14'h0, e.rf_s});
      chk("rf_w_data",  {8'h0,  bus.rf_w_data},  {8'h0,  e.w_data});
      chk("rf_w_addr",  {12'h0, bus.rf_w_addr},  {12'h0, e.wa});
      chk("rf_rp_addr", {12'h0, bus.rf_rp_addr}, {12'h0, e.pa});
      chk("rf_rq_addr", {12'h0, bus.rf_rq_addr}, {12'h0, e.qa});
      chk("rf_w_wr",    {15'h0, bus.rf_w_wr},    {15'h0, e.w_wr});
      chk("rf_rp_rd",   {15'h0, bus.rf_rp_rd},   {15'h0, e.p_rd});
      chk("rf_rq_rd",   {15'h0, bus.rf_rq_rd},   {15'h0, e.q_rd});
      chk("alu_s",      {14'h0, bus.alu_s},      {14'h0, e.alu});
      chk("wr_exclusive", {15'h0, bus.d_wr & bus.rf_w_wr}, 16'h0);
    end
  end

  initial begin
    n_checks       = 0;
    n_errors       = 0;
    rst_n          = 1'b0;
    bus.rf_rp_zero = 1'b0;
    for (int i = 0; i < 256; i++) imem[i] = 16'hF000;

    // Reset, then load-constant at address 0
    imem[8'h00] = 16'h3A05;
    imem[8'h01] = 16'h2123;
    imem[8'h02] = 16'h500E;
    imem[8'h10] = 16'h51FE;
    imem[8'h0E] = 16'h5002;
    imem[8'h11] = 16'h50EE;
    imem[8'hFF] = 16'h0020;
    tick(blank(4'd0, c_pc_reset));
    tick(blank(4'd0, c_pc_reset));
    rst_n = 1'b1;
    m_pc  = c_pc_reset;

    run_instr(1'b0, 1'b1, 8'h00);
    chk("ldc_state",  {12'h0, bus.state_o},   16'h0006);
    chk("ldc_waddr",  {12'h0, bus.rf_w_addr}, 16'h000A);
    chk("ldc_wdata",  {8'h0,  bus.rf_w_data}, 16'h0005);
    chk("ldc_rf_s",   {14'h0, bus.rf_s},      16'h0002);
    chk("ldc_wr",     {15'h0, bus.rf_w_wr},   16'h0001);
    chk("ldc_pc",     {8'h0,  bus.pc_addr},   16'h0001);

    run_instr(1'b0, 1'b1, 8'h01);
    chk("add_state",  {12'h0, bus.state_o},    16'h0005);
    chk("add_waddr",  {12'h0, bus.rf_w_addr},  16'h0001);
    chk("add_paddr",  {12'h0, bus.rf_rp_addr}, 16'h0002);
    chk("add_qaddr",  {12'h0, bus.rf_rq_addr}, 16'h0003);
    chk("add_alu",    {14'h0, bus.alu_s},      16'h0001);
    chk("add_en", {13'h0, bus.rf_w_wr, bus.rf_rp_rd, bus.rf_rq_rd}, 16'h0007);

    // Jump chain: 02 -> 10 (taken, to 0E) -> 0E -> 10 (untaken) -> 11 -> FF
    run_instr(1'b1, 1'b1, 8'h02);
    run_instr(1'b1, 1'b1, 8'h10);
    chk("jmp_state",  {12'h0, bus.state_o}, 16'h0009);
    run_instr(1'b1, 1'b1, 8'h0E);
    run_instr(1'b0, 1'b1, 8'h10);
    run_instr(1'b1, 1'b1, 8'h11);
    run_instr(1'b0, 1'b1, 8'hFF);
    chk("wrap_pc",    {8'h0,  bus.pc_addr}, 16'h0000);
    chk("load_state", {12'h0, bus.state_o}, 16'h0003);
    chk("load_daddr", {8'h0,  bus.d_addr},  16'h0020);
    chk("load_rd",    {15'h0, bus.d_rd},    16'h0001);
    chk("load_rf_s",  {14'h0, bus.rf_s},    16'h0001);

    // NOP, then a store interrupted by reset
    imem[8'h00] = 16'hF000;
    imem[8'h01] = 16'h1480;
    run_instr(1'b0, 1'b1, 8'h00);
    chk("nop_state",  {12'h0, bus.state_o}, 16'h0002);
    chk("nop_strobes", {13'h0, bus.d_rd, bus.d_wr, bus.rf_w_wr}, 16'h0000);
    run_instr(1'b0, 1'b1, 8'h01);
    chk("store_wr",   {15'h0, bus.d_wr},    16'h0001);
    rst_n = 1'b0;
    tick(blank(4'd0, c_pc_reset));
    chk("rst_state",  {12'h0, bus.state_o}, 16'h0000);
    chk("rst_d_wr",   {15'h0, bus.d_wr},    16'h0000);
    chk("rst_pc",     {8'h0,  bus.pc_addr}, {8'h0, c_pc_reset});
    rst_n = 1'b1;
    m_pc  = c_pc_reset;

    // Randomized program against the instruction-level model
    for (int i = 0; i < 256; i++) begin
      imem[i] = {4'($urandom_range(0, 9)), 12'($urandom)};
    end
    for (int n = 0; n < 400; n++) begin
      run_instr(1'($urandom_range(0, 1)), 1'b0, 8'h00);
    end

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bp_control_unit.md
BP_CONTROL_UNIT -- requirements
Module: bp_control_unit

Interface
REQ-001 Parameter: PC_RESET, 8'h00, PC value loaded on reset.
REQ-002 Port: clk  input  1  rising-edge clock, sole clock.
REQ-003 Port: rst_n  input  1  synchronous, active-low reset.
REQ-004 Port: pc_addr  output  8  program counter; drives instruction-memory addr.
REQ-005 Port: i_data  input  16  instruction word from instruction-memory r_data (combinational read).
REQ-006 Port: rf_rp_zero  input  1  high when register-file read port P value is 0.
REQ-007 Port: d_addr  output  8  data-memory address.
REQ-008 Port: d_rd / d_wr  output  1 each  data-memory read / write strobes.
REQ-009 Port: rf_s  output  2  register write mux: 00 ALU, 01 data memory, 10 constant.
REQ-010 Port: rf_w_data  output  8  constant for load-constant.
REQ-011 Port: rf_w_addr, rf_rp_addr, rf_rq_addr  output  4 each  register addresses.
REQ-012 Port: rf_w_wr, rf_rp_rd, rf_rq_rd  output  1 each  register write / read enables.
REQ-013 Port: alu_s  output  2  00 pass, 01 add, 10 subtract.
REQ-014 Port: state_o  output  4  current state encoding, debug.

Function
REQ-015 IR: 16-bit register; fields op=IR[15:12], ra=IR[11:8], rb=IR[7:4], rc=IR[3:0], k=IR[7:0].
REQ-016 States/encoding: INIT 0, FETCH 1, DECODE 2, LOAD 3, STORE 4, ADD 5, LDC 6, SUB 7, JMPZ 8, JMPZ_JMP 9.
REQ-017 INIT -> FETCH unconditionally.
REQ-018 FETCH: IR <= i_data, PC <= PC+1 mod 256 (8'hFF wraps to 8'h00); -> DECODE.
REQ-019 DECODE: op 0000 LOAD, 0001 STORE, 0010 ADD, 0011 LDC, 0100 SUB, 0101 JMPZ; op 0110-1111 -> FETCH (NOP).
REQ-020 LOAD, STORE, ADD, LDC, SUB, JMPZ_JMP each -> FETCH after one cycle.
REQ-021 JMPZ: rf_rp_addr=ra, rf_rp_rd=1; -> JMPZ_JMP if rf_rp_zero=1 sampled this cycle, else FETCH.
REQ-022 JMPZ_JMP: PC <= PC + k - 1 mod 256 (target relative to jump instruction address).
REQ-023 Control outputs Moore-combinational from state and IR; every control output 0 in any state except as listed.
REQ-024 LOAD: d_addr=k, d_rd=1, rf_s=01, rf_w_addr=ra, rf_w_wr=1.
REQ-025 STORE: d_addr=k, d_wr=1, rf_rp_addr=ra, rf_rp_rd=1.
REQ-026 ADD: rf_rp_addr=rb, rf_rq_addr=rc, rf_rp_rd=1, rf_rq_rd=1, alu_s=01, rf_s=00, rf_w_addr=ra, rf_w_wr=1.
REQ-027 SUB: as ADD with alu_s=10.
REQ-028 LDC: rf_s=10, rf_w_data=k, rf_w_addr=ra, rf_w_wr=1.
REQ-029 pc_addr = PC register directly; changes only in FETCH, JMPZ_JMP, reset.
REQ-030 Latency: non-jump instruction 3 cycles FETCH-to-FETCH; taken JMPZ 4 cycles; untaken 3; NOP 2.
REQ-031 d_wr and rf_w_wr never both high; never high in INIT, FETCH, DECODE.

Reset
REQ-032 rst_n low at a rising edge: state <= INIT, PC <= PC_RESET, IR <= 16'h0000, regardless of current state.
REQ-033 During and after reset until FETCH: all control outputs 0, state_o=0, pc_addr=PC_RESET.
REQ-034 Reset mid-instruction (e.g. in STORE) aborts it; no write strobe on the cycle following reset.

Verification
REQ-035 Reset then i_data=16'h3A05 at PC 0 -> INIT,FETCH,DECODE,LDC; in LDC rf_w_addr=A, rf_w_data=05, rf_s=10, rf_w_wr=1; pc_addr=01.
REQ-036 i_data=16'h2123 -> ADD cycle: rf_w_addr=1, rf_rp_addr=2, rf_rq_addr=3, alu_s=01, all three enables 1.
REQ-037 PC=8'h10, i_data=16'h51FE, rf_rp_zero=1 -> JMPZ_JMP taken, next pc_addr=8'h0E; same with rf_rp_zero=0 -> pc_addr=8'h11.
REQ-038 PC=8'hFF fetch of 16'h0020 -> pc_addr wraps to 8'h00; LOAD: d_addr=20, d_rd=1, rf_s=01.
REQ-039 i_data=16'hF000 -> FETCH,DECODE,FETCH, no control strobe asserted.
REQ-040 rst_n low during STORE (16'h1480) -> next cycle state_o=0, d_wr=0, pc_addr=PC_RESET.
